// File: rtl/mulu_8_pkg.sv
// Shared ALU definitions: FSM state encoding (common with the divider) and
// the shift-add iteration count.
package mulu_8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    RESL = 2'b11
  } alu_state_t;

  localparam int unsigned ITER      = 8;
  localparam logic [3:0]  LAST_ITER = 4'(ITER - 1);

endpackage : mulu_8_pkg

// File: rtl/mulu_8.sv
// Sequential unsigned 8x8 multiply-add, P = src1 * src2 + src3, using a fixed
// 8-iteration shift-add datapath with a start/done handshake.
module mulu_8
  import mulu_8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src1,
  input  logic [7:0]  src2,
  input  logic [7:0]  src3,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);

  alu_state_t  r_state;
  logic [3:0]  r_count;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;

  assign busy = (r_state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours; blocking here would chain updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      P        <= '0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done    <= 1'b0;
          r_count <= '0;
          if (start) begin
            // The addend seeds the accumulator, so the add costs no extra cycle.
            r_acc    <= {8'h00, src3};
            r_mcand  <= {8'h00, src1};
            r_mplier <= src2;
            r_state  <= CALC;
          end
        end
        CALC: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 4'd1;
          if (r_count == LAST_ITER) r_state <= RESL;
        end
        RESL: begin
          P       <= r_acc;
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : mulu_8

// File: tb/tb_mulu_8.sv
// Directed and random checks of mulu_8: reset, latency, busy/done shape,
// ignored start, mid-operation reset, back-to-back operation.
module tb_mulu_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  src1, src2, src3;
  logic [15:0] P;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mulu_8 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .src1 (src1),
    .src2 (src2),
    .src3 (src3),
    .P    (P),
    .busy (busy),
    .done (done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge in IDLE; accepts on the next posedge (cycle 0) and
  // returns at the negedge of the cycle where done is seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       output int lat, output bit shape_ok);
    start = 1'b1; src1 = a; src2 = b; src3 = c;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; src1 = ~a; src2 = ~b; src3 = ~c;
    lat = 0;
    shape_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        if (busy !== 1'b0) shape_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) shape_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat;
    bit shape_ok;
    rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; src3 = '0;
    repeat (2) @(negedge clk);
    checks++; if (P !== 16'h0000) begin errors++; $display("FAIL reset_P: got %h want 0000", P); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    // rst and start together: nothing must be accepted
    start = 1'b1; src1 = 8'd9; src2 = 8'd9; src3 = 8'd9;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_beats_start: busy=%b want 0", busy); end
    do_op(8'd3, 8'd4, 8'd0, lat, shape_ok);
    checks++; if (P !== 16'd12) begin errors++; $display("FAIL first_op_P: got %0d want 12", P); end
    checks++; if (lat != 10) begin errors++; $display("FAIL first_op_latency: got %0d want 10", lat); end
    checks++; if (!shape_ok) begin errors++; $display("FAIL first_op_busy_shape: got 0 want 1"); end
    @(negedge clk);
  endtask

  task automatic test_max();
    int lat;
    bit shape_ok;
    do_op(8'd255, 8'd255, 8'd255, lat, shape_ok);
    checks++; if (P !== 16'hFF00) begin errors++; $display("FAIL max_P: got %h want ff00", P); end
    checks++; if (lat != 10) begin errors++; $display("FAIL max_latency: got %0d want 10", lat); end
    checks++; if (!shape_ok) begin errors++; $display("FAIL max_busy_shape: got 0 want 1"); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL max_done_width: got %b want 0", done); end
    checks++; if (P !== 16'hFF00) begin errors++; $display("FAIL max_P_held: got %h want ff00", P); end
  endtask

  task automatic test_divider_inverse();
    int lat;
    bit shape_ok;
    do_op(8'd7, 8'd13, 8'd5, lat, shape_ok);
    checks++; if (P !== 16'd96) begin errors++; $display("FAIL inverse_P: got %0d want 96", P); end
    checks++; if (lat != 10) begin errors++; $display("FAIL inverse_latency: got %0d want 10", lat); end
    @(negedge clk);
    do_op(8'd0, 8'd0, 8'd200, lat, shape_ok);
    checks++; if (P !== 16'd200) begin errors++; $display("FAIL zero_P: got %0d want 200", P); end
    checks++; if (lat != 10) begin errors++; $display("FAIL zero_latency: got %0d want 10", lat); end
    checks++; if (!shape_ok) begin errors++; $display("FAIL zero_busy_shape: got 0 want 1"); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int lat;
    bit shape_ok;
    int early;
    start = 1'b1; src1 = 8'd10; src2 = 8'd10; src3 = 8'd0;
    @(posedge clk);
    @(negedge clk);                          // cycle 1
    start = 1'b0; src1 = 8'd77; src2 = 8'd55; src3 = 8'd33;
    repeat (3) @(negedge clk);               // cycle 4
    start = 1'b1; src1 = 8'd1;
    early = 0;
    if (done === 1'b1) early++;
    for (int c = 5; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) start = 1'b0;
      if (c < 10 && done === 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL ignored_early_done: got %0d want 0", early); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignored_done_c10: got %b want 1", done); end
    checks++; if (P !== 16'd100) begin errors++; $display("FAIL ignored_P: got %0d want 100", P); end
    // Back-to-back: start in cycle 10 while done is high
    do_op(8'd2, 8'd3, 8'd1, lat, shape_ok);
    checks++; if (P !== 16'd7) begin errors++; $display("FAIL b2b_P: got %0d want 7", P); end
    checks++; if (lat != 10) begin errors++; $display("FAIL b2b_latency: got %0d want 10", lat); end
    checks++; if (!shape_ok) begin errors++; $display("FAIL b2b_busy_shape: got 0 want 1"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit shape_ok;
    int pulses;
    start = 1'b1; src1 = 8'd200; src2 = 8'd2; src3 = 8'd0;
    @(posedge clk);
    @(negedge clk);                          // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);               // cycle 5
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (P !== 16'h0000) begin errors++; $display("FAIL midrst_P: got %h want 0000", P); end
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", pulses); end
    checks++; if (P !== 16'h0000) begin errors++; $display("FAIL midrst_P_held: got %h want 0000", P); end
    do_op(8'd5, 8'd6, 8'd1, lat, shape_ok);
    checks++; if (P !== 16'd31) begin errors++; $display("FAIL post_rst_P: got %0d want 31", P); end
    checks++; if (lat != 10) begin errors++; $display("FAIL post_rst_latency: got %0d want 10", lat); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    bit shape_ok;
    logic [7:0]  a, b, c;
    logic [15:0] exp_p;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      exp_p = ({8'h00, a} * {8'h00, b}) + {8'h00, c};
      do_op(a, b, c, lat, shape_ok);
      checks++; if (P !== exp_p) begin errors++; $display("FAIL rand_P[%0d] %0d*%0d+%0d: got %0d want %0d", n, a, b, c, P, exp_p); end
      checks++; if (lat != 10) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 10", n, lat); end
      checks++; if (!shape_ok) begin errors++; $display("FAIL rand_busy_shape[%0d]: got 0 want 1", n); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_done_width: got %b want 0", done); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; src3 = '0;
    @(negedge clk);
    test_reset();
    test_max();
    test_divider_inverse();
    test_ignored_start();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mulu_8
